// File: rtl/pipe_alu_if.sv
// ==== pipe_alu_if : command/result handshake bundle for pipe_alu (rev 1.0) ====
`default_nettype none

interface pipe_alu_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sel;
  logic             use_acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, sel, use_acc, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_n, op_count
  );

  modport master (
    output in_valid, sel, use_acc, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_n, op_count
  );
endinterface

`default_nettype wire

// File: rtl/pipe_alu.sv
// ==== pipe_alu : two-stage pipelined ALU with accumulator and op counter (rev 1.0) ====
`default_nettype none

module pipe_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_alu_if.slave   bus
);

  logic             r_s1_valid;
  logic [2:0]       r_s1_sel;
  logic             r_s1_use_acc;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_flag_z;
  logic             r_flag_c;
  logic             r_flag_n;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_op_count;

  logic             w_s2_can_load;
  logic             w_s2_load;
  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic [WIDTH:0]   w_sum;

  assign w_s2_can_load = !r_out_valid || bus.out_ready;
  assign w_s2_load     = r_s1_valid && w_s2_can_load;
  assign bus.in_ready  = !r_s1_valid || w_s2_can_load;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_xfer        = r_out_valid && bus.out_ready;

  always_comb begin
    w_op_a = r_s1_use_acc ? r_acc : r_s1_a;
    w_sum  = {1'b0, ~w_op_a} + {1'b0, r_s1_b};
    w_res  = '0;
    w_c    = 1'b0;
    case (r_s1_sel)
      3'b001: begin
        w_res = {w_op_a[WIDTH-2:0], 1'b0};
        w_c   = w_op_a[WIDTH-1];
      end
      3'b010: begin
        w_res = {r_s1_b[WIDTH-2:0], 1'b0};
        w_c   = r_s1_b[WIDTH-1];
      end
      3'b011: w_res = ~w_op_a ^ ~r_s1_b;
      3'b100: w_res = w_op_a & ~r_s1_b;
      3'b101: w_res = w_op_a | r_s1_b;
      3'b110: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
      end
      3'b111: w_res = WIDTH'(1);
      default: w_res = '0;
    endcase
  end

  // S1 keeps its valid bit when a new command arrives in the same cycle it drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_sel     <= '0;
      r_s1_use_acc <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid   <= 1'b1;
        r_s1_sel     <= bus.sel;
        r_s1_use_acc <= bus.use_acc;
        r_s1_a       <= bus.a;
        r_s1_b       <= bus.b;
      end else if (w_s2_load) begin
        r_s1_valid   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flag_z    <= 1'b1;
      r_flag_c    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_acc       <= '0;
      r_op_count  <= '0;
    end else begin
      if (w_s2_load) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_flag_z    <= (w_res == '0);
        r_flag_c    <= w_c;
        r_flag_n    <= w_res[WIDTH-1];
        r_acc       <= w_res;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_xfer) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flag_z    = r_flag_z;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_n    = r_flag_n;
  assign bus.op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_pipe_alu.sv
// ==== tb_pipe_alu : randomized + directed self-checking bench for pipe_alu (rev 1.0) ====
`default_nettype none

module tb_pipe_alu;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_alu_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

  pipe_alu #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference: results are computed in acceptance order, so the accumulator is simply the previous result.
  typedef struct {
    logic [7:0] res;
    bit         c;
    bit         shown;
  } ent_t;

  ent_t        mq[$];
  logic [7:0]  m_acc;
  logic [15:0] m_cnt;
  logic [10:0] got[$];

  function automatic logic [8:0] ref_alu(input int s, input int av, input int bv);
    int r;
    int c;
    r = 0;
    c = 0;
    case (s)
      1: begin r = (av * 2) % 256; c = av / 128; end
      2: begin r = (bv * 2) % 256; c = bv / 128; end
      3: r = av ^ bv;
      4: r = av & (255 - bv);
      5: r = av | bv;
      6: begin r = (255 - av) + bv; c = r / 256; r = r % 256; end
      7: r = 1;
      default: r = 0;
    endcase
    return {c[0], r[7:0]};
  endfunction

  function automatic bit m_ovalid();
    return (mq.size() > 0) && mq[0].shown;
  endfunction

  function automatic bit m_iready();
    return (mq.size() < 2) || (bus.out_ready === 1'b1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_acc = '0;
      m_cnt = '0;
    end else begin
      bit         take;
      ent_t       e;
      logic [8:0] r;
      take = bus.in_valid && m_iready();
      if (m_ovalid() && bus.out_ready) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (mq.size() > 0 && !mq[0].shown) begin
        e = mq.pop_front();
        e.shown = 1'b1;
        mq.push_front(e);
      end
      if (take) begin
        r = ref_alu(int'(bus.sel), bus.use_acc ? int'(m_acc) : int'(bus.a), int'(bus.b));
        m_acc = r[7:0];
        e.res = r[7:0];
        e.c = r[8];
        e.shown = 1'b0;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(bus.in_ready), 32'(m_iready()));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ovalid()));
    chk("op_count", 32'(bus.op_count), 32'(m_cnt));
    if (m_ovalid()) begin
      chk("result", 32'(bus.result), 32'(mq[0].res));
      chk("flag_c", 32'(bus.flag_c), 32'(mq[0].c));
      chk("flag_z", 32'(bus.flag_z), 32'(mq[0].res == 8'h00));
      chk("flag_n", 32'(bus.flag_n), 32'(mq[0].res[7]));
    end
    if (rst_n && bus.out_valid && bus.out_ready)
      got.push_back({bus.flag_n, bus.flag_c, bus.flag_z, bus.result});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s, input logic ua, input logic [7:0] av, input logic [7:0] bv);
    bit ok;
    int guard;
    ok = 1'b0;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.sel = s;
    bus.use_acc = ua;
    bus.a = av;
    bus.b = bv;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    got.delete();
  endtask

  task automatic expect_got(input string nm, input logic [7:0] res, input logic c);
    logic [10:0] g;
    chk({nm, "_present"}, 32'(got.size() > 0), 32'd1);
    if (got.size() > 0) begin
      g = got.pop_front();
      chk({nm, "_res"}, 32'(g[7:0]), 32'(res));
      chk({nm, "_c"}, 32'(g[9]), 32'(c));
    end
  endtask

  logic [7:0] exp8[8] = '{8'h00, 8'h02, 8'h06, 8'h82, 8'h80, 8'h83, 8'h81, 8'h01};
  logic       expc[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int guard;
    logic [10:0] g;
    bus.in_valid = 1'b0;
    bus.sel = '0;
    bus.use_acc = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flag_z", 32'(bus.flag_z), 32'd1);
    chk("rst_flag_c", 32'(bus.flag_c), 32'd0);
    chk("rst_flag_n", 32'(bus.flag_n), 32'd0);
    chk("rst_op_count", 32'(bus.op_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // all opcodes, a=0x81 b=0x03
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(3'(i), 1'b0, 8'h81, 8'h03);
    step(4);
    for (int i = 0; i < 8; i++) expect_got($sformatf("op%0d", i), exp8[i], expc[i]);
    @(negedge clk);
    chk("op_count_8", 32'(bus.op_count), 32'd8);

    // flags
    step(1);
    got.delete();
    send(3'b110, 1'b0, 8'h00, 8'h01);
    send(3'b110, 1'b0, 8'h05, 8'h03);
    step(4);
    chk("flags1_present", 32'(got.size() >= 2), 32'd1);
    if (got.size() >= 2) begin
      g = got.pop_front();
      chk("flags1", 32'(g), 32'({1'b0, 1'b1, 1'b1, 8'h00}));
      g = got.pop_front();
      chk("flags2", 32'(g), 32'({1'b1, 1'b0, 1'b0, 8'hFD}));
    end

    // accumulate
    pulse_reset();
    send(3'b110, 1'b0, 8'hFF, 8'h01);
    for (int i = 0; i < 3; i++) send(3'b001, 1'b1, 8'h55, 8'hAA);
    step(4);
    expect_got("acc0", 8'h01, 1'b0);
    expect_got("acc1", 8'h02, 1'b0);
    expect_got("acc2", 8'h04, 1'b0);
    expect_got("acc3", 8'h08, 1'b0);

    // backpressure
    pulse_reset();
    bus.out_ready = 1'b0;
    send(3'b101, 1'b0, 8'h10, 8'h01);
    send(3'b011, 1'b0, 8'hF0, 8'h0F);
    bus.in_valid = 1'b1;
    bus.sel = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold", 32'(bus.result), 32'h11);
      step(1);
    end
    bus.out_ready = 1'b1;
    send(3'b111, 1'b0, 8'h00, 8'h00);
    step(4);
    expect_got("bp0", 8'h11, 1'b0);
    expect_got("bp1", 8'hFF, 1'b0);
    expect_got("bp2", 8'h01, 1'b0);
    @(negedge clk);
    chk("bp_count", 32'(bus.op_count), 32'd3);

    // reset with two commands in flight
    step(1);
    bus.out_ready = 1'b0;
    send(3'b101, 1'b0, 8'h01, 8'h02);
    send(3'b101, 1'b0, 8'h04, 8'h08);
    got.delete();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step(5);
    chk("mid_rst_no_xfer", 32'(got.size()), 32'd0);
    chk("mid_rst_count", 32'(bus.op_count), 32'd0);

    // randomized traffic
    pulse_reset();
    for (int i = 0; i < 2000; i++) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.sel = 3'($urandom);
      bus.use_acc = 1'($urandom);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.out_ready = ($urandom % 10) < 7;
      step(1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step(3);

    // counter wrap
    pulse_reset();
    bus.in_valid = 1'b1;
    bus.sel = 3'b000;
    bus.out_ready = 1'b1;
    guard = 0;
    @(negedge clk);
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    chk("wrap_reached", 32'(m_cnt == 16'hFFFF), 32'd1);
    chk("wrap_ffff", 32'(bus.op_count), 32'hFFFF);
    @(negedge clk);
    chk("wrap_zero", 32'(bus.op_count), 32'h0000);
    bus.in_valid = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
